// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the iterative multiplier.
//   state_t  : controller states (IDLE -> CALC -> FIX -> IDLE)
//   clog2    : counter width helper
//   bpc_ok   : legality test for the WIDTH / BITS_PER_CYCLE pair
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Bit n set means n multiplier bits per cycle is a supported step size (1, 2, 4).
  localparam logic [4:0] BPC_LEGAL_MASK = 5'b10110;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit bpc_ok(input int width, input int bpc);
    if (bpc < 1 || bpc > 4) return 1'b0;
    if (!BPC_LEGAL_MASK[bpc]) return 1'b0;
    if ((width % bpc) != 0) return 1'b0;
    if (width < 4 || (width % 2) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// mul_iter_if: request/response bundle of the iterative multiplier.
//   master drives : start, is_signed, a, b, cancel
//   slave drives  : busy, done, hi, lo
interface mul_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_step.sv
// mul_step: one combinational radix-2^BPC accumulation step.
//   i_acc   : running unsigned 2*WIDTH partial sum
//   i_mag_a : multiplicand magnitude
//   i_digit : current BPC-bit multiplier digit
//   i_cnt   : index of the digit (weight 2^(i_cnt*BPC))
//   o_acc   : i_acc + (i_digit * i_mag_a) << (i_cnt*BPC)
module mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1,
  parameter int CNT_W = 6
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [BPC-1:0]     i_digit,
  input  logic [CNT_W-1:0]   i_cnt,
  output logic [2*WIDTH-1:0] o_acc
);
  localparam int PW   = WIDTH + BPC;
  localparam int SH_W = CNT_W + 3;

  logic [PW-1:0]      w_part;
  logic [2*WIDTH-1:0] w_part_ext;
  logic [SH_W-1:0]    w_shamt;

  assign w_part     = PW'(i_digit) * PW'(i_mag_a);
  assign w_part_ext = (2*WIDTH)'(w_part);
  assign w_shamt    = SH_W'(i_cnt) * SH_W'(BPC);
  // Highest weight placed is (ITER-1)*BPC + WIDTH + BPC = 2*WIDTH, so no carry is lost.
  assign o_acc      = i_acc + (w_part_ext << w_shamt);

endmodule

// File: rtl/mul_iter.sv
// mul_iter: multi-cycle MULT/MULTU unit, BITS_PER_CYCLE multiplier bits per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.start/is_signed/a/b : request, sampled only while idle
//   bus.cancel : flush; aborts an operation in CALC or FIX
//   bus.busy   : state != IDLE
//   bus.done   : one-cycle pulse when hi/lo are written
//   bus.hi/lo  : upper/lower halves of the 2*WIDTH product
// Magnitudes are multiplied unsigned; the sign is applied once in FIX.
module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic       clk,
  input logic       rst_n,
  mul_iter_if.slave bus
);
  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = clog2(ITER + 1);

  if (!bpc_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("mul_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide an even WIDTH >= 4");
  end
  if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
    $error("mul_iter: interface WIDTH does not match module WIDTH");
  end

  state_t             r_state;
  logic               r_neg;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_product;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is still exact when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] sx;
    sx = signed'(x);
    if (sgn && sx < 0) return WIDTH'(-sx);
    return x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] acc,
                                                    input logic neg);
    logic signed [2*WIDTH-1:0] sacc;
    sacc = signed'(acc);
    return neg ? (2*WIDTH)'(-sacc) : acc;
  endfunction

  mul_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE),
    .CNT_W (CNT_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_mag_a (r_mag_a),
    .i_digit (r_mag_b[BITS_PER_CYCLE-1:0]),
    .i_cnt   (r_cnt),
    .o_acc   (w_acc_next)
  );

  assign w_product = apply_sign(r_acc, r_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_neg   <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Accept: capture operand magnitudes and result sign.
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            r_mag_a <= magnitude(bus.a, bus.is_signed);
            r_mag_b <= magnitude(bus.b, bus.is_signed);
            r_neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        // Iterate: one multiplier digit per clock, LSB digit first.
        S_CALC: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(ITER - 1)) r_state <= S_FIX;
          end
        end
        // Fix-up: negate if needed and publish; a flush here still wins.
        S_FIX: begin
          r_state <= S_IDLE;
          if (!bus.cancel) begin
            {r_hi, r_lo} <= w_product;
            r_done       <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: scoreboard bench for mul_iter at BITS_PER_CYCLE = 1 and 4.
// Stimulus pushes the expected 64-bit product when an operation will complete;
// an independent monitor pops and compares on every done pulse.
module tb_mul_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int          sel = 0;
  int          iter = 32;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic prev_done = 1'b0;

  logic        busy_m, done_m;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  mul_iter_if #(.WIDTH(32)) if1 ();
  mul_iter_if #(.WIDTH(32)) if4 ();

  assign if1.start     = start && (sel == 0);
  assign if1.cancel    = cancel && (sel == 0);
  assign if1.is_signed = is_signed;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if4.start     = start && (sel == 1);
  assign if4.cancel    = cancel && (sel == 1);
  assign if4.is_signed = is_signed;
  assign if4.a         = a;
  assign if4.b         = b;

  assign busy_m = (sel == 0) ? if1.busy : if4.busy;
  assign done_m = (sel == 0) ? if1.done : if4.done;
  assign hi_m   = (sel == 0) ? if1.hi   : if4.hi;
  assign lo_m   = (sel == 0) ? if1.lo   : if4.lo;

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (bpc cfg %0d): got %h required %h", name, sel, act, req);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic sg);
    logic signed [63:0] sx, sy;
    if (sg) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Monitor: every done pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (done_m) begin
      check("done_single_cycle", {63'b0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done (bpc cfg %0d): got %h_%h required no done", sel, hi_m, lo_m);
      end else begin
        check("result", {hi_m, lo_m}, exp_q.pop_front());
      end
    end
    prev_done <= done_m;
  end

  // Called at a negedge with the DUT idle; checks busy/done cycle by cycle.
  task automatic op_timed(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isg, input logic [63:0] expv);
    int bad_busy;
    int bad_done;
    bad_busy = 0;
    bad_done = 0;
    exp_q.push_back(expv);
    start = 1'b1; a = ia; b = ib; is_signed = isg;
    for (int i = 1; i <= iter + 2; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i <= iter + 1) begin
        if (busy_m !== 1'b1) bad_busy++;
        if (done_m !== 1'b0) bad_done++;
      end else if (busy_m !== 1'b0) begin
        bad_busy++;
      end
    end
    check({name, "_done_at_iter_plus_2"}, {63'b0, done_m}, 64'd1);
    check({name, "_busy_pattern"}, 64'(bad_busy), 64'd0);
    check({name, "_no_early_done"}, 64'(bad_done), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy_m && k < iter + 6) begin
      @(negedge clk);
      k++;
    end
    if (busy_m) check({name, "_timeout"}, {63'b0, busy_m}, 64'd0);
  endtask

  task automatic run_suite();
    int k;
    int nd;
    int s;
    logic [31:0] ra, rb;
    logic rs;

    // Signed and unsigned directed products.
    op_timed("s3xm5", 32'd3, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
    op_timed("u_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    op_timed("s_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
    op_timed("s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    op_timed("s_minx1", 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000);
    op_timed("s_0xm7", 32'h00000000, 32'hFFFFFFF9, 1'b1, 64'h0);

    // start held while busy is ignored; start in the done cycle is accepted.
    exp_q.push_back(64'd63);
    exp_q.push_back(64'hFFFFFFFF_FFFFF830);
    start = 1'b1; a = 32'd7; b = 32'd9; is_signed = 1'b0;
    @(negedge clk);
    a = 32'hFFFFFFFE; b = 32'h000003E8; is_signed = 1'b1;
    k = 0;
    while (!done_m && k < iter + 4) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_latency", 64'(k), 64'(iter + 1));
    @(negedge clk);
    check("b2b_busy_after_done", {63'b0, busy_m}, 64'd1);
    start = 1'b0;
    wait_idle("b2b_second");

    // cancel at CALC step 5: no done, hi/lo keep the previous result.
    start = 1'b1; a = 32'd11; b = 32'd13; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_calc_busy", {63'b0, busy_m}, 64'd0);
    nd = 0;
    for (int i = 0; i < iter + 3; i++) begin
      @(negedge clk);
      if (done_m) nd++;
    end
    check("cancel_calc_no_done", 64'(nd), 64'd0);
    check("cancel_calc_hilo_kept", {hi_m, lo_m}, 64'hFFFFFFFF_FFFFF830);
    op_timed("after_cancel", 32'd12, 32'd12, 1'b0, 64'h90);

    // cancel landing on the FIX edge beats the write-back.
    start = 1'b1; a = 32'd3; b = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (iter) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_fix_busy", {63'b0, busy_m}, 64'd0);
    check("cancel_fix_done", {63'b0, done_m}, 64'd0);
    check("cancel_fix_hilo_kept", {hi_m, lo_m}, 64'h90);

    // start together with cancel in IDLE is dropped.
    start = 1'b1; cancel = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_idle", {63'b0, busy_m}, 64'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; a = 32'd5; b = 32'd5; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'b0, busy_m}, 64'd0);
    check("async_rst_done", {63'b0, done_m}, 64'd0);
    check("async_rst_hilo", {hi_m, lo_m}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_timed("post_rst_7x6", 32'd7, 32'd6, 1'b0, 64'h2A);

    // Random operands with random idle gaps and random cancel points.
    for (int n = 0; n < 150; n++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start = 1'b1; a = ra; b = rb; is_signed = rs;
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(1, iter + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (s - 1) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("rand_cancel_busy", {63'b0, busy_m}, 64'd0);
      end else begin
        exp_q.push_back(ref_prod(ra, rb, rs));
        @(negedge clk);
        start = 1'b0;
        wait_idle("rand_op");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      sel = c;
      #0;
      check("reset_busy", {63'b0, busy_m}, 64'd0);
      check("reset_done", {63'b0, done_m}, 64'd0);
      check("reset_hilo", {hi_m, lo_m}, 64'd0);
    end
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);

    sel = 0; iter = 32;
    run_suite();
    sel = 1; iter = 8;
    @(negedge clk);
    run_suite();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
